// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- registered ALU with accumulator, registered flags, a start/done
// handshake and a multi-cycle unsigned shift-add multiplier.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst_n    synchronous active-low reset
//   start    operation request, sampled only while busy = 0
//   op       operation select: ADD SUB AND OR XOR SHL SHR MUL
//   a, b     operands (WIDTH bits)
//   c_in     carry in, used by ADD only
//   use_acc  1: operand A is taken from r instead of a
//   busy     high while a MUL is in progress
//   done     one-cycle pulse when r/hi/flags hold a new result
//   r        result / accumulator (MUL: low half of the product)
//   hi       MUL high half, 0 after any other op
//   zero     result is zero (MUL: whole product is zero)
//   c_out    carry flag, meaning depends on op
//   sign     r[WIDTH-1]
//   ovf      signed overflow for ADD/SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             use_acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             c_out,
    output logic             sign,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_t;

    // Registered state
    state_t             state;
    logic [2*WIDTH-1:0] prod;     // running product
    logic [2*WIDTH-1:0] mcand;    // multiplicand, shifted left each iteration
    logic [WIDTH-1:0]   mplier;   // multiplier, shifted right each iteration
    logic [CW-1:0]      cnt;      // iteration counter

    // Next-state values
    state_t             state_n;
    logic [2*WIDTH-1:0] prod_n;
    logic [2*WIDTH-1:0] mcand_n;
    logic [WIDTH-1:0]   mplier_n;
    logic [CW-1:0]      cnt_n;
    logic [WIDTH-1:0]   r_n;
    logic [WIDTH-1:0]   hi_n;
    logic               zero_n;
    logic               c_out_n;
    logic               sign_n;
    logic               ovf_n;
    logic               done_n;

    // Single-cycle datapath
    logic [WIDTH-1:0]   opa;
    logic [WIDTH:0]     sum_add;
    logic [WIDTH:0]     sum_sub;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    // Multiplier step
    logic [2*WIDTH-1:0] prod_step;
    logic               mul_last;

    assign opa     = use_acc ? r : a;
    assign sum_add = {1'b0, opa} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
    // SUB as A + ~B + 1: bit WIDTH of the sum is the "no borrow" carry.
    assign sum_sub = {1'b0, opa} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statements can leave a latch behind.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_t'(op))
            OP_ADD: begin
                alu_res = sum_add[WIDTH-1:0];
                alu_c   = sum_add[WIDTH];
                alu_v   = (opa[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_add[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sum_sub[WIDTH-1:0];
                alu_c   = sum_sub[WIDTH];
                alu_v   = (opa[WIDTH-1] != b[WIDTH-1]) &&
                          (sum_sub[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND:  alu_res = opa & b;
            OP_OR:   alu_res = opa | b;
            OP_XOR:  alu_res = opa ^ b;
            OP_SHL: begin
                alu_res = {opa[WIDTH-2:0], 1'b0};
                alu_c   = opa[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, opa[WIDTH-1:1]};
                alu_c   = opa[0];
            end
            default: ;
        endcase
    end

    // One shift-add iteration: add the shifted multiplicand when the current
    // multiplier bit is set. The full product never exceeds 2*WIDTH bits.
    assign prod_step = prod + (mplier[0] ? mcand : '0);
    assign mul_last  = (cnt == CW'(WIDTH - 1));

    // Next-state and output logic
    always_comb begin
        state_n  = state;
        prod_n   = prod;
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
        r_n      = r;
        hi_n     = hi;
        zero_n   = zero;
        c_out_n  = c_out;
        sign_n   = sign;
        ovf_n    = ovf;
        done_n   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    if (op_t'(op) == OP_MUL) begin
                        mcand_n  = {{WIDTH{1'b0}}, opa};
                        mplier_n = b;
                        prod_n   = '0;
                        cnt_n    = '0;
                        state_n  = MUL;
                    end else begin
                        r_n     = alu_res;
                        hi_n    = '0;
                        zero_n  = (alu_res == '0);
                        c_out_n = alu_c;
                        sign_n  = alu_res[WIDTH-1];
                        ovf_n   = alu_v;
                        done_n  = 1'b1;
                    end
                end
            end
            MUL: begin
                prod_n   = prod_step;
                mcand_n  = {mcand[2*WIDTH-2:0], 1'b0};
                mplier_n = {1'b0, mplier[WIDTH-1:1]};
                cnt_n    = cnt + CW'(1);
                if (mul_last) begin
                    state_n = IDLE;
                    r_n     = prod_step[WIDTH-1:0];
                    hi_n    = prod_step[2*WIDTH-1:WIDTH];
                    zero_n  = (prod_step == '0);
                    c_out_n = (prod_step[2*WIDTH-1:WIDTH] != '0);
                    sign_n  = prod_step[WIDTH-1];
                    ovf_n   = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register. Reset aborts a MUL in progress without a done pulse.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            r      <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            c_out  <= 1'b0;
            sign   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            prod   <= prod_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            cnt    <= cnt_n;
            r      <= r_n;
            hi     <= hi_n;
            zero   <= zero_n;
            c_out  <= c_out_n;
            sign   <= sign_n;
            ovf    <= ovf_n;
            busy   <= (state_n == MUL);
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- directed self-checking bench for alu_seq (WIDTH = 8).
// Expected results come from an integer reference model, are queued when an
// operation is issued, and are compared whenever the DUT pulses done.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] r;
        logic         zero;
        logic         c_out;
        logic         sign;
        logic         ovf;
    } res_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         use_acc;
    logic         busy;
    logic         done;
    logic [W-1:0] r;
    logic [W-1:0] hi;
    logic         zero;
    logic         c_out;
    logic         sign;
    logic         ovf;

    int           n_vec = 0;
    int           n_err = 0;
    res_t         exp_q[$];
    string        tag_q[$];
    logic [W-1:0] model_r = '0;

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .c_in    (c_in),
        .use_acc (use_acc),
        .busy    (busy),
        .done    (done),
        .r       (r),
        .hi      (hi),
        .zero    (zero),
        .c_out   (c_out),
        .sign    (sign),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model written with plain integer arithmetic.
    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input logic ci);
        int   ua = av;
        int   ub = bv;
        int   sa = $signed(av);
        int   sb = $signed(bv);
        int   t  = 0;
        int   s  = 0;
        res_t e  = '0;
        case (o)
            3'd0: begin
                t = ua + ub + ci;
                s = sa + sb + ci;
                e.r = t[W-1:0];
                e.c_out = (t > 255);
                e.ovf = (s > 127) || (s < -128);
            end
            3'd1: begin
                t = ua - ub;
                s = sa - sb;
                e.r = t[W-1:0];
                e.c_out = (ua >= ub);
                e.ovf = (s > 127) || (s < -128);
            end
            3'd2: e.r = av & bv;
            3'd3: e.r = av | bv;
            3'd4: e.r = av ^ bv;
            3'd5: begin
                t = ua * 2;
                e.r = t[W-1:0];
                e.c_out = av[W-1];
            end
            3'd6: begin
                t = ua / 2;
                e.r = t[W-1:0];
                e.c_out = av[0];
            end
            default: begin
                t = ua * ub;
                e.r = t[W-1:0];
                e.hi = t[2*W-1:W];
                e.c_out = (t > 255);
            end
        endcase
        e.zero = ({e.hi, e.r} == '0);
        e.sign = e.r[W-1];
        return e;
    endfunction

    // Drive one request (start stays high until the caller drops it) and
    // queue the expected result.
    task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic ci, input logic ua);
        res_t e;
        op = o; a = av; b = bv; c_in = ci; use_acc = ua; start = 1'b1;
        e = model(o, ua ? model_r : av, bv, ci);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        model_r = e.r;
    endtask

    // Single-cycle op: done is high for exactly the cycle after the accept edge.
    task automatic single(input string tag, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic ci, input logic ua);
        issue(tag, o, av, bv, ci, ua);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"}, done, 1);
        @(negedge clk);
        check({tag, "_done_fall"}, done, 0);
    endtask

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                res_t  e;
                string t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, {hi, r, zero, c_out, sign, ovf}, e);
            end
        end
    end

    initial begin
        logic [W-1:0] prev_r;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; c_in = 1'b0; use_acc = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, hi, r, zero, c_out, sign, ovf}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD with carry in and carry out
        single("add_f0_20", 3'd0, 8'hF0, 8'h20, 1'b1, 1'b0);
        check("add_r_11", r, 8'h11);

        // SUB with signed overflow, then SUB to zero
        single("sub_80_01", 3'd1, 8'h80, 8'h01, 1'b0, 1'b0);
        check("sub_ovf", ovf, 1);
        single("sub_33_33", 3'd1, 8'h33, 8'h33, 1'b1, 1'b0);
        check("sub_zero", zero, 1);

        // Accumulate chain
        single("acc_add_05", 3'd0, 8'h05, 8'h00, 1'b0, 1'b0);
        single("acc_add_03", 3'd0, 8'hFF, 8'h03, 1'b0, 1'b1);
        check("acc_r_08", r, 8'h08);
        single("acc_shl", 3'd5, 8'h00, 8'h00, 1'b0, 1'b1);
        check("acc_r_10", r, 8'h10);

        // MUL FF*FF with an ignored start during busy
        prev_r = model_r;
        issue("mul_ff_ff", 3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("mul_busy_0", busy, 1);
        for (int j = 1; j < W; j++) begin
            if (j == 3) begin
                op = 3'd0; a = 8'h01; b = 8'h01; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            check($sformatf("mul_busy_%0d", j), {busy, done, r}, {2'b10, prev_r});
        end
        start = 1'b0;
        @(negedge clk);
        check("mul_end", {busy, done}, 2'b01);
        check("mul_hi_fe", hi, 8'hFE);
        @(negedge clk);
        check("mul_done_fall", done, 0);

        // Reset in the middle of a MUL
        issue("mul_0f_0f", 3'd7, 8'h0F, 8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        tag_q.delete();
        model_r = '0;
        @(negedge clk);
        check("mid_mul_reset", {busy, done, hi, r, zero, c_out, sign, ovf}, 0);
        rst_n = 1'b1;
        for (int j = 0; j <= W; j++) begin
            @(negedge clk);
            check($sformatf("no_done_after_abort_%0d", j), {busy, done}, 0);
        end
        single("post_reset_add", 3'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        check("post_reset_r_02", r, 8'h02);

        // Back-to-back: start held high over two consecutive ops
        issue("b2b_shr", 3'd6, 8'h01, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_done_1", done, 1);
        check("b2b_shr_flags", {r, zero, c_out}, {8'h00, 2'b11});
        issue("b2b_xor", 3'd4, 8'hAA, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_done_2", done, 1);
        check("b2b_r_55", r, 8'h55);
        @(negedge clk);
        check("b2b_done_fall", done, 0);

        // Idle: outputs hold, no done
        repeat (3) @(negedge clk);
        check("idle_hold", {done, r}, {1'b0, 8'h55});
        check("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
